// File: rtl/attack_wave_ctrl.sv
// attack_wave_ctrl: launch scheduler for a pool of falling attackers.
// Paces launches and waves on the frame tick and latches game over.
//
// Ports:
//   clk_65M      pixel clock
//   clear        sync active-high reset
//   game_on      play enable (level)
//   game_stop    sync abort, same effect as clear
//   H_count      horizontal pixel counter
//   V_count      vertical line counter
//   atk_done     per-slot pulse, slot has been freed
//   atk_hit      per-slot level, attacker overlaps shooter
//   atk_launch   one-hot pulse, load start position into slot
//   atk_x_start  launch column, valid with atk_launch
//   atk_speed    shared fall speed
//   slot_active  slot occupancy map
//   wave_num     completed-wave count
//   game_over    sticky loss flag
module attack_wave_ctrl #(
  parameter int NSLOT     = 4,
  parameter int WAVE_SIZE = 6,
  parameter int SPAWN_GAP = 30,
  parameter int X_MIN     = 200,
  parameter int X_SPAN    = 780,
  parameter int SPD_INIT  = 2,
  parameter int SPD_MAX   = 9
) (
  input  logic             clk_65M,
  input  logic             clear,
  input  logic             game_on,
  input  logic             game_stop,
  input  logic [16:0]      H_count,
  input  logic [16:0]      V_count,
  input  logic [NSLOT-1:0] atk_done,
  input  logic [NSLOT-1:0] atk_hit,
  output logic [NSLOT-1:0] atk_launch,
  output logic [16:0]      atk_x_start,
  output logic [3:0]       atk_speed,
  output logic [NSLOT-1:0] slot_active,
  output logic [7:0]       wave_num,
  output logic             game_over
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GAP    = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WEND   = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;

  localparam logic [7:0]  GAP_LD = 8'(SPAWN_GAP);
  localparam logic [7:0]  WSZ    = 8'(WAVE_SIZE);
  localparam logic [9:0]  SPAN   = 10'(X_SPAN);
  localparam logic [16:0] X0     = 17'(X_MIN);
  localparam logic [3:0]  SPD0   = 4'(SPD_INIT);
  localparam logic [3:0]  SPDM   = 4'(SPD_MAX);
  localparam logic [9:0]  SEED   = 10'h2A5;

  logic [2:0]       state_q, state_d;
  logic [7:0]       gap_q, gap_d;
  logic [7:0]       launched_q, launched_d;
  logic [NSLOT-1:0] active_q, active_d;
  logic [7:0]       wave_q, wave_d;
  logic [3:0]       spd_q, spd_d;
  logic             over_q, over_d;
  logic [NSLOT-1:0] launch_q, launch_d;
  logic [16:0]      x_q, x_d;
  logic [9:0]       lfsr_q, lfsr_d;

  logic             frame_tick;
  logic             hit;
  logic [9:0]       xr;
  logic [NSLOT-1:0] avail;
  logic [NSLOT-1:0] pick;
  logic             found;

  assign frame_tick = (H_count == 17'd0) && (V_count == 17'd0);
  assign hit        = frame_tick && (|(atk_hit & active_q));
  assign lfsr_d     = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  assign xr         = (lfsr_q >= SPAN) ? (lfsr_q - SPAN) : lfsr_q;

  // A slot freed this very cycle is not reused until the next launch.
  assign avail = ~active_q & ~atk_done;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (avail[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    launched_d = launched_q;
    active_d   = active_q;
    wave_d     = wave_q;
    spd_d      = spd_q;
    over_d     = over_q;
    launch_d   = '0;
    x_d        = x_q;

    if (state_q != S_IDLE) active_d = active_q & ~atk_done;

    unique case (state_q)
      S_IDLE: begin
        if (game_on) begin
          gap_d   = GAP_LD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (frame_tick && gap_q != 8'd0) gap_d = gap_q - 8'd1;
        if (gap_q == 8'd0 && launched_q < WSZ && (|(~active_q)))
          state_d = S_LAUNCH;
        else if (launched_q == WSZ && active_q == '0)
          state_d = S_WEND;
      end
      S_LAUNCH: begin
        state_d = S_GAP;
        // No candidate: gap stays at 0 so GAP retries next cycle.
        if (found) begin
          launch_d   = pick;
          active_d   = active_d | pick;
          x_d        = X0 + {7'd0, xr};
          launched_d = launched_q + 8'd1;
          gap_d      = GAP_LD;
        end
      end
      S_WEND: begin
        wave_d     = wave_q + 8'd1;
        spd_d      = (spd_q >= SPDM) ? SPDM : spd_q + 4'd1;
        launched_d = 8'd0;
        gap_d      = GAP_LD;
        state_d    = S_GAP;
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!game_on && (state_q == S_GAP || state_q == S_LAUNCH ||
                     state_q == S_WEND)) begin
      state_d    = S_IDLE;
      active_d   = '0;
      launched_d = 8'd0;
      launch_d   = '0;
    end

    // A hit freezes everything else that would happen this cycle.
    if (hit && state_q != S_IDLE) begin
      state_d    = S_OVER;
      over_d     = 1'b1;
      launch_d   = '0;
      active_d   = active_q;
      launched_d = launched_q;
      gap_d      = gap_q;
      wave_d     = wave_q;
      spd_d      = spd_q;
      x_d        = x_q;
    end
  end

  always_ff @(posedge clk_65M) begin
    if (clear || game_stop) begin
      state_q    <= S_IDLE;
      gap_q      <= 8'd0;
      launched_q <= 8'd0;
      active_q   <= '0;
      wave_q     <= 8'd0;
      spd_q      <= SPD0;
      over_q     <= 1'b0;
      launch_q   <= '0;
      x_q        <= 17'd0;
      lfsr_q     <= SEED;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      launched_q <= launched_d;
      active_q   <= active_d;
      wave_q     <= wave_d;
      spd_q      <= spd_d;
      over_q     <= over_d;
      launch_q   <= launch_d;
      x_q        <= x_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign atk_launch  = launch_q;
  assign atk_x_start = x_q;
  assign atk_speed   = spd_q;
  assign slot_active = active_q;
  assign wave_num    = wave_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_attack_wave_ctrl.sv
// tb_attack_wave_ctrl: scoreboard bench for attack_wave_ctrl.
// Short 4-clock frames; expected launches queued, popped on atk_launch.
module tb_attack_wave_ctrl;

  logic        clk;
  logic        clear;
  logic        game_on;
  logic        game_stop;
  logic [16:0] h;
  logic [16:0] v;
  logic [3:0]  atk_done;
  logic [3:0]  atk_hit;
  logic [3:0]  atk_launch;
  logic [16:0] atk_x_start;
  logic [3:0]  atk_speed;
  logic [3:0]  slot_active;
  logic [7:0]  wave_num;
  logic        game_over;

  attack_wave_ctrl dut (
    .clk_65M     (clk),
    .clear       (clear),
    .game_on     (game_on),
    .game_stop   (game_stop),
    .H_count     (h),
    .V_count     (v),
    .atk_done    (atk_done),
    .atk_hit     (atk_hit),
    .atk_launch  (atk_launch),
    .atk_x_start (atk_x_start),
    .atk_speed   (atk_speed),
    .slot_active (slot_active),
    .wave_num    (wave_num),
    .game_over   (game_over)
  );

  typedef struct {
    logic [3:0] slot;
    int         frame;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk   = 0;
  int         n_pass  = 0;
  int         n_launch = 0;
  int         fcnt    = 0;
  int         last_lf = 0;
  bit         sb_en   = 1;
  logic [3:0] prev_active = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame = 2 columns x 2 lines; tick when both counters are 0.
  initial begin
    h = '0;
    v = '0;
    forever begin
      @(posedge clk);
      #1;
      if (h == 17'd1) begin
        h = '0;
        v = (v == 17'd1) ? 17'd0 : 17'd1;
      end else begin
        h = h + 17'd1;
      end
      if (h == 17'd0 && v == 17'd0) fcnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (atk_launch != 4'd0) begin
      n_launch++;
      last_lf = fcnt;
      chk("launch_onehot", int'($onehot0(atk_launch)), 1);
      chk("launch_free", int'(atk_launch & prev_active), 0);
      chk("x_range", int'(atk_x_start >= 17'd200 && atk_x_start <= 17'd979), 1);
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          chk("unexp_launch", int'(atk_launch), 0);
        end else begin
          e = exp_q.pop_front();
          chk("launch_slot", int'(atk_launch), int'(e.slot));
          if (e.frame >= 0) chk("launch_frame", fcnt, e.frame);
        end
      end
    end
    prev_active = slot_active;
  end

  task automatic push(input logic [3:0] s, input int f);
    exp_t e;
    e.slot  = s;
    e.frame = f;
    exp_q.push_back(e);
  endtask

  task automatic wait_launch(input int budget);
    int n0;
    bit got;
    n0  = n_launch;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (n_launch != n0) begin
        got = 1;
        break;
      end
    end
    chk("launch_seen", int'(got), 1);
  endtask

  task automatic wait_frame(input int tgt);
    bit ok;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (h == 17'd0 && v == 17'd0 && fcnt == tgt) begin
        ok = 1;
        break;
      end
    end
    chk("frame_reach", int'(ok), 1);
  endtask

  task automatic run_wave(input int w);
    int spd;
    for (int k = 0; k < 6; k++) begin
      push(4'b0001, (k == 0) ? last_lf + 31 : last_lf + 30);
      wait_launch(1000);
      @(negedge clk);
      atk_done = 4'b0001;
      @(negedge clk);
      atk_done = 4'b0000;
    end
    repeat (6) @(negedge clk);
    spd = (2 + w > 9) ? 9 : 2 + w;
    chk("wave_num", int'(wave_num), w);
    chk("wave_speed", int'(atk_speed), spd);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_launch"}, int'(atk_launch), 0);
    chk({tag, "_active"}, int'(slot_active), 0);
    chk({tag, "_wave"}, int'(wave_num), 0);
    chk({tag, "_speed"}, int'(atk_speed), 2);
    chk({tag, "_over"}, int'(game_over), 0);
    chk({tag, "_x"}, int'(atk_x_start), 0);
  endtask

  initial begin
    int s;
    int t;
    int n0;
    clear     = 1'b1;
    game_on   = 1'b0;
    game_stop = 1'b0;
    atk_done  = '0;
    atk_hit   = '0;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    chk_reset("rst");

    // First launch 30 frames after start, then 4 in total.
    game_on = 1'b1;
    s = fcnt;
    for (int k = 1; k <= 4; k++) push(4'(1 << (k - 1)), s + 30 * k);
    for (int k = 0; k < 4; k++) begin
      wait_launch(800);
      if (k == 0) chk("first_active", int'(slot_active), 1);
    end
    repeat (200) @(posedge clk);
    chk("no_5th", n_launch, 4);
    chk("full_active", int'(slot_active), 15);
    chk("queue_empty", exp_q.size(), 0);

    // Freeing slot 2 lets the waiting 5th launch take it.
    t = fcnt + 2;
    push(4'b0100, t);
    wait_frame(t);
    atk_done = 4'b0100;
    @(negedge clk);
    atk_done = 4'b0000;
    wait_launch(100);
    chk("refill_active", int'(slot_active), 15);

    // Free everything; 6th launch, then the wave ends.
    t = last_lf;
    wait_frame(t + 5);
    atk_done = 4'b1111;
    @(negedge clk);
    atk_done = 4'b0000;
    push(4'b0001, t + 30);
    wait_launch(800);
    @(negedge clk);
    atk_done = 4'b0001;
    @(negedge clk);
    atk_done = 4'b0000;
    repeat (6) @(negedge clk);
    chk("wave1_num", int'(wave_num), 1);
    chk("wave1_speed", int'(atk_speed), 3);
    chk("wave1_active", int'(slot_active), 0);
    for (int w = 2; w <= 9; w++) run_wave(w);

    // Hit on active slot 1 together with its done pulse.
    push(4'b0001, last_lf + 31);
    wait_launch(1000);
    push(4'b0010, last_lf + 30);
    wait_launch(1000);
    wait_frame(last_lf + 2);
    atk_hit  = 4'b0010;
    atk_done = 4'b0010;
    @(negedge clk);
    atk_hit  = 4'b0000;
    atk_done = 4'b0000;
    repeat (3) @(negedge clk);
    chk("hit_over", int'(game_over), 1);
    n0 = n_launch;
    repeat (400) @(negedge clk);
    chk("over_nolaunch", n_launch, n0);
    game_on = 1'b0;
    repeat (8) @(negedge clk);
    game_on = 1'b1;
    repeat (8) @(negedge clk);
    chk("over_sticky", int'(game_over), 1);
    chk("over_wave", int'(wave_num), 9);
    clear   = 1'b1;
    game_on = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    chk_reset("clr");

    // Hit on an inactive slot is ignored.
    game_on = 1'b1;
    s = fcnt;
    push(4'b0001, s + 30);
    wait_launch(800);
    wait_frame(last_lf + 2);
    atk_hit = 4'b1000;
    @(negedge clk);
    atk_hit = 4'b0000;
    repeat (3) @(negedge clk);
    chk("idle_hit_over", int'(game_over), 0);
    push(4'b0010, s + 60);
    wait_launch(800);

    // game_stop in the LAUNCH cycle (two cycles after the zeroing tick).
    wait_frame(s + 90);
    @(negedge clk);
    @(negedge clk);
    game_stop = 1'b1;
    @(negedge clk);
    chk("stop_launch", int'(atk_launch), 0);
    chk("stop_active", int'(slot_active), 0);
    game_stop = 1'b0;
    t = fcnt;
    push(4'b0001, t + 30);
    wait_launch(800);
    chk("stop_queue", exp_q.size(), 0);

    // Random sweep: properties checked by the monitor on every launch.
    sb_en = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      clear    = game_over;
      atk_done = ($urandom_range(0, 7) == 0) ?
                 (slot_active & 4'($urandom_range(0, 15))) : 4'd0;
      atk_hit  = ($urandom_range(0, 299) == 0) ?
                 4'($urandom_range(0, 15)) : 4'd0;
      if ($urandom_range(0, 2999) == 0) game_on = ~game_on;
    end
    atk_done = '0;
    atk_hit  = '0;
    clear    = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    chk("sweep_launches", int'(n_launch > 20), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
